ena_scheduler: RTL and testbench
================================

Name: ena_scheduler

Overview:
- Generates the per-signal `ena` vector for the synchronous model of an asynchronous circuit.
- Each cycle the model's FFs are enabled only where this block permits; it chooses which excited signal(s) fire, one firing per step.
- Sits beside the generated circuit model. `excited[i]` comes from comparing each FF's D with its Q, and `ena` drives `ena[]` of the circuit.
- Provides round-robin, pseudo-random and maximal-parallel interleavings, plus deadlock detection.

Parameters:
- N, 8, number of enable bits (inputs + gates); must be >= 2.
- LFSR_W, 16, width of the random-selection LFSR.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- STALL_LIMIT, 4, consecutive empty SELECT cycles in run mode before deadlock is flagged.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- mode  in  2  00 round-robin, 01 random, 10 max-parallel, 11 treated as 00; sampled in SELECT.
- run  in  1  level: free-running stepping.
- step_req  in  1  single-step request pulse; honoured only in IDLE.
- excited  in  N  per-signal excitation (D != Q) from the circuit model.
- ena  out  N  registered enable vector to the circuit model.
- fire_valid  out  1  high in the FIRE cycle when ena != 0.
- fire_idx  out  $clog2(N)  index fired; lowest set bit in max-parallel mode.
- step_done  out  1  one-cycle pulse when a single step completes.
- deadlock  out  1  sticky flag: no excitation for STALL_LIMIT selects.
- fire_count  out  32  number of FIRE events, saturating at 32'hFFFF_FFFF.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low, named `reset`.
- Reset state:
  - State goes to IDLE.
  - All outputs are 0.
  - Round-robin pointer `ptr` = 0, LFSR = SEED, stall counter = 0.
  - A reset asserted mid-operation aborts the step; `ena` is 0 on the following cycle.
- State IDLE:
  - If run = 1, go to SELECT.
  - Otherwise, if step_req = 1, go to SELECT and latch `single` = 1.
  - Otherwise stay.
- State SELECT (`excited` is sampled this cycle):
  - excited != 0:
    - The chosen enable vector is registered into `ena`; go to FIRE.
    - Stall counter clears.
  - excited == 0 in run mode:
    - Stall counter increments.
    - If it reaches STALL_LIMIT, go to DEADLOCK; otherwise go to SETTLE with `ena` = 0.
  - excited == 0 in single mode: pulse step_done, fire_valid stays 0, go to IDLE.
  - The LFSR advances once in every SELECT cycle (Galois, maximal-length taps).
- Selection rules:
  - Round-robin: winner = first set bit of `excited` at index >= ptr, wrapping to 0. On fire, ptr <= (winner + 1) mod N.
  - Random: start = LFSR mod N, then the same wrapped search; ptr is unchanged.
  - Max-parallel: ena = excited (all excited signals together); fire_idx = lowest set index.
- State FIRE:
  - `ena` is high for exactly this cycle; fire_valid = 1.
  - fire_count increments by 1, saturating.
  - `ena` clears at the end of the cycle; go to SETTLE.
- State SETTLE:
  - One cycle for the circuit Q and the combinational excitation to update.
  - If `single` is set: pulse step_done, clear `single`, go to IDLE.
  - Otherwise, if run = 1, go to SELECT; if run = 0, go to IDLE.
- State DEADLOCK:
  - deadlock = 1 and ena = 0.
  - Stays until run = 0, then goes to IDLE. deadlock stays set until reset.
  - step_req is ignored while deadlock = 1.
- Throughput: in run mode one firing every 3 cycles (SELECT, FIRE, SETTLE).
- Latency: step_req in IDLE at cycle t gives ena at t+2 and step_done at t+3.
- run dropping during FIRE or SETTLE finishes the current step, then goes to IDLE; no step_done pulse in run mode.
- step_req outside IDLE is ignored (not queued).
- Changes to `excited` outside SELECT are ignored.

Decomposition:
- Package `sched_pkg`:
  - State enum: IDLE, SELECT, FIRE, SETTLE, DEADLOCK.
  - Mode constants: MODE_RR, MODE_RAND, MODE_PAR.
  - LFSR tap constant for width 16.
- Sub-module `wrap_pick`:
  - Combinational priority search of an N-bit mask from a start index, with wrap-around.
  - Outputs: found, idx, one-hot.
  - Shared by the round-robin and random modes.

Test Plan:
- Round-robin: N=8, mode=00, run=1, excited=8'b1000_0101 held → fire_idx sequence 0, 2, 7, 0, 2 at 3-cycle spacing; ena one-hot; fire_count = 5.
- Single step: IDLE, step_req pulse at t, excited=8'h10 → ena=8'h10 at t+2 only, step_done at t+3, fire_count = 1. A second step_req during SETTLE is ignored.
- Max-parallel: mode=10, excited=8'h3C → ena=8'h3C for one cycle, fire_idx = 2, fire_valid = 1.
- Deadlock: run=1, excited=0, STALL_LIMIT=4 → deadlock rises after the 4th SELECT; ena stays 0; drop run → IDLE, deadlock still 1.
- Random: mode=01, SEED=16'hACE1, excited=8'hFF → fire_idx sequence matches the reference LFSR model; all indices stay within 0..7.
- Reset mid-FIRE: reset=0 during FIRE → next cycle ena=0, fire_count=0, state IDLE, ptr=0.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and constants for the ena scheduler.
package sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        FIRE,
        SETTLE,
        DEADLOCK
    } sched_state_e;

    // Interleaving modes; encoding 2'b11 falls back to round-robin.
    localparam logic [1:0] MODE_RR   = 2'b00;
    localparam logic [1:0] MODE_RAND = 2'b01;
    localparam logic [1:0] MODE_PAR  = 2'b10;

    // Right-shifting Galois taps for a maximal-length 16-bit LFSR (x^16+x^14+x^13+x^11+1).
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

endpackage

// File: rtl/wrap_pick.sv
// Wrap-around priority search: first set bit of mask at index >= start, wrapping to 0.
module wrap_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx,
    output logic [N-1:0]         onehot
);

    localparam int unsigned IdxW = $clog2(N);
    localparam logic [IdxW:0] NVal = (IdxW+1)'(N);

    logic [N-1:0]    rot;
    logic [IdxW-1:0] off;
    logic [IdxW:0]   sum;

    // Rotate so that bit 'start' lands at bit 0, find the lowest set offset, map it back.
    always_comb begin
        rot   = N'({mask, mask} >> start);
        found = |rot;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IdxW'(k);
            end
        end
        // start and off are both < N, so a single conditional subtract is enough.
        sum    = {1'b0, start} + {1'b0, off};
        idx    = (sum >= NVal) ? IdxW'(sum - NVal) : sum[IdxW-1:0];
        onehot = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/ena_scheduler.sv
// Chooses which excited signals of the synchronous circuit model fire each step.
module ena_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int unsigned STALL_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic                 run,
    input  logic                 step_req,
    input  logic [N-1:0]         excited,
    output logic [N-1:0]         ena,
    output logic                 fire_valid,
    output logic [$clog2(N)-1:0] fire_idx,
    output logic                 step_done,
    output logic                 deadlock,
    output logic [31:0]          fire_count
);

    localparam int unsigned IdxW   = $clog2(N);
    localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

    sched_state_e      state_q, state_d;
    logic [N-1:0]      ena_q, ena_d;
    logic              fire_valid_q, fire_valid_d;
    logic [IdxW-1:0]   fire_idx_q, fire_idx_d;
    logic              step_done_q, step_done_d;
    logic              deadlock_q, deadlock_d;
    logic [31:0]       fire_count_q, fire_count_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [StallW-1:0] stall_q, stall_d;
    logic              single_q, single_d;

    logic [IdxW-1:0]   rand_start;
    logic [IdxW-1:0]   pick_start;
    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic [N-1:0]      pick_onehot;
    logic [LFSR_W-1:0] lfsr_next;

    assign rand_start = IdxW'(lfsr_q % LFSR_W'(N));
    assign lfsr_next  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_W'(LFSR_TAPS_16) : '0);

    // Search start per mode; max-parallel searches from 0 to report the lowest index.
    always_comb begin
        pick_start = ptr_q;
        case (mode)
            MODE_RAND: pick_start = rand_start;
            MODE_PAR:  pick_start = '0;
            default:   pick_start = ptr_q;
        endcase
    end

    wrap_pick #(
        .N (N)
    ) u_wrap_pick (
        .mask   (excited),
        .start  (pick_start),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Next-state and registered-output logic for the stepping FSM.
    always_comb begin
        state_d      = state_q;
        ena_d        = '0;
        fire_valid_d = 1'b0;
        fire_idx_d   = '0;
        step_done_d  = 1'b0;
        deadlock_d   = deadlock_q;
        fire_count_d = fire_count_q;
        ptr_d        = ptr_q;
        lfsr_d       = lfsr_q;
        stall_d      = stall_q;
        single_d     = single_q;

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = SELECT;
                end else if (step_req && !deadlock_q) begin
                    state_d  = SELECT;
                    single_d = 1'b1;
                end
            end
            SELECT: begin
                lfsr_d = lfsr_next;
                if (pick_found) begin
                    state_d      = FIRE;
                    stall_d      = '0;
                    fire_valid_d = 1'b1;
                    fire_idx_d   = pick_idx;
                    ena_d        = (mode == MODE_PAR) ? excited : pick_onehot;
                    if (mode != MODE_RAND && mode != MODE_PAR) begin
                        ptr_d = (pick_idx == IdxW'(N - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end else if (single_q) begin
                    state_d     = IDLE;
                    single_d    = 1'b0;
                    step_done_d = 1'b1;
                end else if (stall_q == StallW'(STALL_LIMIT - 1)) begin
                    state_d    = DEADLOCK;
                    deadlock_d = 1'b1;
                    stall_d    = '0;
                end else begin
                    state_d = SETTLE;
                    stall_d = stall_q + 1'b1;
                end
            end
            FIRE: begin
                state_d = SETTLE;
                if (fire_count_q != 32'hFFFF_FFFF) begin
                    fire_count_d = fire_count_q + 32'd1;
                end
                // step_done is registered, so raise it now to appear during SETTLE.
                step_done_d = single_q;
            end
            SETTLE: begin
                if (single_q) begin
                    state_d  = IDLE;
                    single_d = 1'b0;
                end else if (run) begin
                    state_d = SELECT;
                end else begin
                    state_d = IDLE;
                end
            end
            DEADLOCK: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            ena_q        <= '0;
            fire_valid_q <= 1'b0;
            fire_idx_q   <= '0;
            step_done_q  <= 1'b0;
            deadlock_q   <= 1'b0;
            fire_count_q <= '0;
            ptr_q        <= '0;
            lfsr_q       <= SEED;
            stall_q      <= '0;
            single_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ena_q        <= ena_d;
            fire_valid_q <= fire_valid_d;
            fire_idx_q   <= fire_idx_d;
            step_done_q  <= step_done_d;
            deadlock_q   <= deadlock_d;
            fire_count_q <= fire_count_d;
            ptr_q        <= ptr_d;
            lfsr_q       <= lfsr_d;
            stall_q      <= stall_d;
            single_q     <= single_d;
        end
    end

    assign ena        = ena_q;
    assign fire_valid = fire_valid_q;
    assign fire_idx   = fire_idx_q;
    assign step_done  = step_done_q;
    assign deadlock   = deadlock_q;
    assign fire_count = fire_count_q;

endmodule

// File: tb/tb_ena_scheduler.sv
// Scoreboard bench for ena_scheduler: expected firings queued by stimulus, popped by a monitor.
module tb_ena_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        run = 1'b0;
    logic        step_req = 1'b0;
    logic [7:0]  excited = 8'h00;
    logic [7:0]  ena;
    logic        fire_valid;
    logic [2:0]  fire_idx;
    logic        step_done;
    logic        deadlock;
    logic [31:0] fire_count;

    typedef struct packed {
        logic [7:0] ena;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    ena_scheduler #(
        .N           (8),
        .LFSR_W      (16),
        .SEED        (16'hACE1),
        .STALL_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .run        (run),
        .step_req   (step_req),
        .excited    (excited),
        .ena        (ena),
        .fire_valid (fire_valid),
        .fire_idx   (fire_idx),
        .step_done  (step_done),
        .deadlock   (deadlock),
        .fire_count (fire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] e, input logic [2:0] i);
        exp_t x;
        x.ena = e;
        x.idx = i;
        exp_q.push_back(x);
    endtask

    // Waits (bounded) for the next fire_valid, returning the number of negedges waited.
    task automatic wait_fire(input string name, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!fire_valid && cycles < 30);
        if (!fire_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no fire within %0d cycles, expected one", name, cycles);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        run      = 1'b0;
        step_req = 1'b0;
        excited  = 8'h00;
        mode     = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every FIRE cycle must match the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (fire_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_fire: got ena=%0h idx=%0d, expected no fire",
                             ena, fire_idx);
                end else begin
                    x = exp_q.pop_front();
                    check("fire_ena", {24'h0, ena}, {24'h0, x.ena});
                    check("fire_idx", {29'h0, fire_idx}, {29'h0, x.idx});
                end
            end else if (ena != 8'h00) begin
                n_vec++;
                n_err++;
                $display("FAIL ena_without_fire: got ena=%0h, expected 0", ena);
            end
        end
    end

    initial begin
        int c;
        logic [2:0] rnd_seq [6];
        rnd_seq = '{3'd1, 3'd0, 3'd0, 3'd4, 3'd6, 3'd7};

        // Reset state.
        do_reset();
        check("rst_ena", {24'h0, ena}, 32'h0);
        check("rst_fire_valid", {31'h0, fire_valid}, 32'h0);
        check("rst_fire_idx", {29'h0, fire_idx}, 32'h0);
        check("rst_step_done", {31'h0, step_done}, 32'h0);
        check("rst_deadlock", {31'h0, deadlock}, 32'h0);
        check("rst_fire_count", fire_count, 32'h0);

        // Round-robin over 1000_0101: 0, 2, 7, 0, 2 at 3-cycle spacing.
        mode    = 2'b00;
        excited = 8'b1000_0101;
        push(8'h01, 3'd0);
        push(8'h04, 3'd2);
        push(8'h80, 3'd7);
        push(8'h01, 3'd0);
        push(8'h04, 3'd2);
        run = 1'b1;
        wait_fire("rr_first", c);
        check("rr_latency", c, 2);
        for (int k = 1; k < 5; k++) begin
            wait_fire("rr_next", c);
            check("rr_spacing", c, 3);
        end
        run = 1'b0;
        repeat (6) @(negedge clk);
        check("rr_count", fire_count, 32'd5);
        check("rr_queue", exp_q.size(), 0);

        // Single step with excited=8'h10; a second request in SETTLE is dropped.
        do_reset();
        excited  = 8'h10;
        push(8'h10, 3'd4);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        check("ss_t1_ena", {24'h0, ena}, 32'h0);
        @(negedge clk);
        check("ss_t2_ena", {24'h0, ena}, 32'h10);
        check("ss_t2_done", {31'h0, step_done}, 32'h0);
        @(negedge clk);
        check("ss_t3_done", {31'h0, step_done}, 32'h1);
        check("ss_t3_ena", {24'h0, ena}, 32'h0);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        check("ss_t4_done", {31'h0, step_done}, 32'h0);
        repeat (6) @(negedge clk);
        check("ss_count", fire_count, 32'd1);

        // Max-parallel: all excited fire together, idx = lowest.
        do_reset();
        mode     = 2'b10;
        excited  = 8'h3C;
        push(8'h3C, 3'd2);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        wait_fire("par_fire", c);
        check("par_latency", c, 1);
        repeat (4) @(negedge clk);
        check("par_count", fire_count, 32'd1);

        // Deadlock after the 4th empty SELECT (SELECT/SETTLE pairs).
        do_reset();
        excited = 8'h00;
        run     = 1'b1;
        repeat (7) @(negedge clk);
        check("dl_before", {31'h0, deadlock}, 32'h0);
        @(negedge clk);
        check("dl_rise", {31'h0, deadlock}, 32'h1);
        check("dl_ena", {24'h0, ena}, 32'h0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("dl_sticky", {31'h0, deadlock}, 32'h1);
        excited  = 8'hFF;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (5) @(negedge clk);
        check("dl_step_ignored", fire_count, 32'd0);
        check("dl_still", {31'h0, deadlock}, 32'h1);

        // Random mode from SEED 16'hACE1 with all bits excited.
        do_reset();
        mode    = 2'b01;
        excited = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            push(8'h01 << rnd_seq[k], rnd_seq[k]);
        end
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_fire("rand_fire", c);
        end
        run = 1'b0;
        repeat (6) @(negedge clk);
        check("rand_count", fire_count, 32'd6);

        // Reset during FIRE aborts the step and clears ptr.
        do_reset();
        excited = 8'h81;
        push(8'h01, 3'd0);
        run = 1'b1;
        wait_fire("rst_mid_fire", c);
        reset = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        check("rmf_ena", {24'h0, ena}, 32'h0);
        check("rmf_valid", {31'h0, fire_valid}, 32'h0);
        check("rmf_count", fire_count, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        push(8'h01, 3'd0);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (5) @(negedge clk);
        check("rmf_step_count", fire_count, 32'd1);

        check("final_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
